// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stream buffer.
// Provides the FSM state encodings, bus tag constants and width helper
// functions used by fetch_stream_buffer and fetch_byte_ring.
package fetch_pkg;

  // FSM state encodings
  localparam logic [2:0] StBoot  = 3'd0;
  localparam logic [2:0] StIdle  = 3'd1;
  localparam logic [2:0] StReq   = 3'd2;
  localparam logic [2:0] StResp  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  // Bus tag fields; the wrapper drives reqtag = BusReqTag alongside req.
  localparam logic [3:0]  BusRead   = 4'b0001;
  localparam logic [3:0]  BusMemory = 4'b0001;
  localparam logic [15:0] BusReqTag = {BusRead, BusMemory, 8'b0};

  function automatic int unsigned beats_per_line(input int unsigned line_bytes,
                                                 input int unsigned beat_bytes);
    return line_bytes / beat_bytes;
  endfunction

  // Width of a pointer into an n-entry ring (at least 1 bit).
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter holding 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_byte_ring.sv
// Circular byte store for the fetch stream buffer.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (pointers only)
//   clear       - synchronous pointer clear, dominates write and advance
//   wr_valid    - write beat bytes wr_first..BEAT_BYTES-1 starting at wr_ptr
//   wr_first    - index of the first beat byte to keep (earlier bytes skipped)
//   wr_data     - beat data, byte j at [8j+:8]
//   rd_adv      - bytes retired this cycle (advances rd_ptr)
//   win_bytes   - WINDOW_BYTES bytes read from rd_ptr, wrapping
module fetch_byte_ring
  import fetch_pkg::*;
#(
  parameter int unsigned BEAT_BYTES   = 8,
  parameter int unsigned BUF_BYTES    = 128,
  parameter int unsigned WINDOW_BYTES = 15,
  localparam int unsigned PtrW   = ptr_width(BUF_BYTES),
  localparam int unsigned FirstW = cnt_width(BEAT_BYTES),
  localparam int unsigned AdvW   = cnt_width(WINDOW_BYTES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      wr_valid,
  input  logic [FirstW-1:0]         wr_first,
  input  logic [BEAT_BYTES*8-1:0]   wr_data,
  input  logic [AdvW-1:0]           rd_adv,
  output logic [WINDOW_BYTES*8-1:0] win_bytes
);

  logic [7:0]      mem_q [BUF_BYTES];
  logic [7:0]      mem_d [BUF_BYTES];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q + PtrW'(rd_adv);
    if (wr_valid) begin
      wr_ptr_d = wr_ptr_q + PtrW'(BEAT_BYTES) - PtrW'(wr_first);
    end
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Kept bytes are packed contiguously: beat byte j lands at wr_ptr + (j - wr_first).
  always_comb begin
    mem_d = mem_q;
    if (wr_valid && !clear) begin
      for (int j = 0; j < BEAT_BYTES; j++) begin
        if (j >= int'(wr_first)) begin
          mem_d[wr_ptr_q + PtrW'(j) - PtrW'(wr_first)] = wr_data[8*j +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WINDOW_BYTES; i++) begin
      win_bytes[8*i +: 8] = mem_q[rd_ptr_q + PtrW'(i)];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Data storage needs no reset; bytes beyond the valid count are don't-care.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_stream_buffer.sv
// Instruction-fetch front end: requests line-sized reads, packs returned
// beats into a byte ring and exposes a decoder window.
// Ports:
//   clk, reset                    - clock, asynchronous active-high reset
//   entry                         - boot fetch address (stable while reset high)
//   redirect_valid, redirect_rip  - flush and restart fetch at redirect_rip
//   reqcyc, req, reqack           - line read request handshake
//   respcyc, resp, respack        - response beats (always accepted)
//   win_bytes, win_count, consume - decoder window, valid bytes, bytes retired
//   busy                          - a request or response is outstanding
module fetch_stream_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned BEAT_BYTES   = 8,
  parameter int unsigned LINE_BYTES   = 64,
  parameter int unsigned BUF_BYTES    = 128,
  parameter int unsigned WINDOW_BYTES = 15
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [63:0]                          entry,
  input  logic                                 redirect_valid,
  input  logic [63:0]                          redirect_rip,
  output logic                                 reqcyc,
  output logic [63:0]                          req,
  input  logic                                 reqack,
  input  logic                                 respcyc,
  input  logic [BEAT_BYTES*8-1:0]              resp,
  output logic                                 respack,
  output logic [WINDOW_BYTES*8-1:0]            win_bytes,
  output logic [$clog2(BUF_BYTES+1)-1:0]       win_count,
  input  logic [$clog2(WINDOW_BYTES+1)-1:0]    consume,
  output logic                                 busy
);

  localparam int unsigned Bpl    = beats_per_line(LINE_BYTES, BEAT_BYTES);
  localparam int unsigned CntW   = cnt_width(BUF_BYTES);
  localparam int unsigned BeatW  = cnt_width(Bpl);
  localparam int unsigned LineW  = ptr_width(LINE_BYTES);
  localparam int unsigned FirstW = cnt_width(BEAT_BYTES);
  localparam logic [63:0]     LineMask  = 64'(LINE_BYTES - 1);
  localparam logic [CntW-1:0] FillLimit = CntW'(BUF_BYTES - LINE_BYTES);
  localparam logic [CntW:0]   BufCap    = (CntW+1)'(BUF_BYTES);

  logic [2:0]       state_q, state_d;
  logic [63:0]      fetch_line_q, fetch_line_d;
  logic [LineW-1:0] skip_q, skip_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [BeatW-1:0] drain_q, drain_d;
  logic             reqcyc_q, reqcyc_d;
  logic [63:0]      req_q, req_d;
  logic [CntW-1:0]  win_count_q, win_count_d;

  logic              wr_valid;
  logic [FirstW-1:0] wr_first;
  logic [CntW-1:0]   written;
  logic [31:0]       beat_base;
  logic [BeatW-1:0]  beats_left;

  always_comb begin
    state_d      = state_q;
    fetch_line_d = fetch_line_q;
    skip_d       = skip_q;
    beat_d       = beat_q;
    drain_d      = drain_q;
    reqcyc_d     = reqcyc_q;
    req_d        = req_q;
    wr_valid     = 1'b0;
    wr_first     = '0;
    written      = '0;
    beats_left   = '0;
    beat_base    = 32'(beat_q) * BEAT_BYTES;

    case (state_q)
      StBoot: begin
        fetch_line_d = entry & ~LineMask;
        skip_d       = LineW'(entry & LineMask);
        state_d      = StIdle;
      end
      StIdle: begin
        // Only ask for a line when it is guaranteed to fit.
        if (win_count_q <= FillLimit) begin
          state_d  = StReq;
          reqcyc_d = 1'b1;
          req_d    = fetch_line_q;
        end
      end
      StReq: begin
        if (reqack) begin
          reqcyc_d = 1'b0;
          beat_d   = '0;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (respcyc) begin
          // Drop bytes below the misaligned start offset.
          if (32'(skip_q) < beat_base + BEAT_BYTES) begin
            wr_valid = 1'b1;
            if (32'(skip_q) > beat_base) begin
              wr_first = FirstW'(32'(skip_q) - beat_base);
            end
            written = CntW'(BEAT_BYTES) - CntW'(wr_first);
          end
          beat_d = beat_q + BeatW'(1);
          if (beat_q == BeatW'(Bpl - 1)) begin
            fetch_line_d = fetch_line_q + 64'(LINE_BYTES);
            skip_d       = '0;
            state_d      = StIdle;
          end
        end
      end
      StDrain: begin
        if (respcyc) begin
          drain_d = drain_q - BeatW'(1);
          if (drain_q == BeatW'(1)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (redirect_valid) begin
      wr_valid     = 1'b0;
      written      = '0;
      reqcyc_d     = 1'b0;
      fetch_line_d = redirect_rip & ~LineMask;
      skip_d       = LineW'(redirect_rip & LineMask);
      case (state_q)
        StReq: begin
          if (reqack) begin
            state_d = StDrain;
            drain_d = BeatW'(Bpl);
          end else begin
            state_d = StIdle;
          end
        end
        StResp: begin
          // A beat arriving this cycle counts as received and is discarded.
          beats_left = BeatW'(Bpl) - beat_q - BeatW'(respcyc);
          drain_d    = beats_left;
          state_d    = (beats_left == '0) ? StIdle : StDrain;
        end
        StDrain: begin
          beats_left = drain_q - BeatW'(respcyc);
          drain_d    = beats_left;
          state_d    = (beats_left == '0) ? StIdle : StDrain;
        end
        default: state_d = StIdle;
      endcase
    end

    win_count_d = redirect_valid ? '0 : (win_count_q + written - CntW'(consume));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StBoot;
      fetch_line_q <= '0;
      skip_q       <= '0;
      beat_q       <= '0;
      drain_q      <= '0;
      reqcyc_q     <= 1'b0;
      req_q        <= '0;
      win_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_line_q <= fetch_line_d;
      skip_q       <= skip_d;
      beat_q       <= beat_d;
      drain_q      <= drain_d;
      reqcyc_q     <= reqcyc_d;
      req_q        <= req_d;
      win_count_q  <= win_count_d;
    end
  end

  fetch_byte_ring #(
    .BEAT_BYTES  (BEAT_BYTES),
    .BUF_BYTES   (BUF_BYTES),
    .WINDOW_BYTES(WINDOW_BYTES)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .clear    (redirect_valid),
    .wr_valid (wr_valid),
    .wr_first (wr_first),
    .wr_data  (resp),
    .rd_adv   (consume),
    .win_bytes(win_bytes)
  );

  assign reqcyc    = reqcyc_q;
  assign req       = req_q;
  assign respack   = respcyc;
  assign win_count = win_count_q;
  // BOOT is a one-cycle reload step with nothing outstanding, so it is not busy.
  assign busy      = (state_q == StReq) || (state_q == StResp) || (state_q == StDrain);

  assert property (@(posedge clk) disable iff (reset) consume <= win_count_q);
  assert property (@(posedge clk) disable iff (reset)
                   ({1'b0, win_count_q} + {1'b0, written}) <= BufCap);

endmodule
